thread_scheduler: RTL and testbench

THREAD_SCHEDULER -- requirements
Module: thread_scheduler

---
 rtl/thread_scheduler.sv | 99 +++++++++
 tb/tb_thread_scheduler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/thread_scheduler.sv
// rtl/thread_scheduler.sv - round-robin fetch thread scheduler with per-thread mispredict penalty
// Four hardware threads; grants are registered and one cycle behind eligibility.
module thread_scheduler #(
   parameter int FLUSH_PENALTY = 3,
   parameter int CNT_WIDTH     = 2
) (
   input  logic       i_Clk,
   input  logic       i_Reset,
   input  logic       i_Stall,
   input  logic [3:0] i_thread_enable,
   input  logic [3:0] i_icache_miss,
   input  logic [7:0] i_branch_mispredict,
   output logic [1:0] o_thread_choice,
   output logic       o_thread_valid,
   output logic [3:0] o_penalty_busy
);

   localparam logic [CNT_WIDTH-1:0] LP_PENALTY_LOAD = CNT_WIDTH'(FLUSH_PENALTY);

   logic [CNT_WIDTH-1:0] r_penalty_cnt [4];
   logic [1:0]           r_last_grant;
   logic [1:0]           r_thread_choice;
   logic                 r_thread_valid;

   logic [3:0]           w_mispredict;
   logic [3:0]           w_eligible;
   logic                 w_found;
   logic [1:0]           w_winner;
   logic [1:0]           w_idx;
   logic [3:0]           w_unused_taken;

   // Even bits carry the mispredict strobe; odd bits are taken flags we do not use.
   assign w_mispredict   = {i_branch_mispredict[6], i_branch_mispredict[4],
                            i_branch_mispredict[2], i_branch_mispredict[0]};
   assign w_unused_taken = {i_branch_mispredict[7], i_branch_mispredict[5],
                            i_branch_mispredict[3], i_branch_mispredict[1]};

   always_comb begin
      w_eligible = '0;
      for (int t = 0; t < 4; t++) begin
         w_eligible[t] = i_thread_enable[t] & ~i_icache_miss[t] &
                         (r_penalty_cnt[t] == '0) & ~w_mispredict[t];
      end
   end

   // Search starts one past the last grant, so the previous winner is tried last.
   always_comb begin
      w_found  = 1'b0;
      w_winner = r_last_grant;
      w_idx    = r_last_grant;
      for (int k = 1; k <= 4; k++) begin
         w_idx = r_last_grant + 2'(k);
         if (!w_found && w_eligible[w_idx]) begin
            w_found  = 1'b1;
            w_winner = w_idx;
         end
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_thread_choice <= 2'd0;
         r_thread_valid  <= 1'b0;
         r_last_grant    <= 2'd3;
      end else if (!i_Stall) begin
         if (w_found) begin
            r_thread_choice <= w_winner;
            r_thread_valid  <= 1'b1;
            r_last_grant    <= w_winner;
         end else begin
            r_thread_valid  <= 1'b0;
         end
      end
   end

   // Penalty counters ignore the stall so a flushed thread recovers on schedule.
   always_ff @(posedge i_Clk) begin
      for (int t = 0; t < 4; t++) begin
         if (i_Reset) begin
            r_penalty_cnt[t] <= '0;
         end else if (w_mispredict[t]) begin
            r_penalty_cnt[t] <= LP_PENALTY_LOAD;
         end else if (r_penalty_cnt[t] != '0) begin
            r_penalty_cnt[t] <= r_penalty_cnt[t] - 1'b1;
         end
      end
   end

   always_comb begin
      o_penalty_busy = '0;
      for (int t = 0; t < 4; t++) begin
         o_penalty_busy[t] = (r_penalty_cnt[t] != '0);
      end
   end

   assign o_thread_choice = r_thread_choice;
   assign o_thread_valid  = r_thread_valid;

endmodule

// File: tb/tb_thread_scheduler.sv
// tb/tb_thread_scheduler.sv - self-checking bench for thread_scheduler
// Directed scenarios plus random traffic against a behavioural model.
module tb_thread_scheduler;

   localparam int FP = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       stall = 1'b0;
   logic [3:0] en = 4'b0000;
   logic [3:0] miss = 4'b0000;
   logic [7:0] mp = 8'h00;
   logic [1:0] choice;
   logic       valid;
   logic [3:0] busy;

   int n_checks = 0;
   int n_errors = 0;

   int m_pen [4];
   int m_last = 3;
   int m_choice = 0;
   int m_valid = 0;

   thread_scheduler #(.FLUSH_PENALTY(FP), .CNT_WIDTH(2)) dut (
      .i_Clk(clk),
      .i_Reset(rst),
      .i_Stall(stall),
      .i_thread_enable(en),
      .i_icache_miss(miss),
      .i_branch_mispredict(mp),
      .o_thread_choice(choice),
      .o_thread_valid(valid),
      .o_penalty_busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] model_busy();
      logic [3:0] b;
      for (int t = 0; t < 4; t++) b[t] = (m_pen[t] > 0);
      return b;
   endfunction

   // Drive one cycle of inputs, advance the model by the same edge, sample 1ns after it.
   task automatic step(input logic s_rst, input logic s_stall, input logic [3:0] s_en,
                       input logic [3:0] s_miss, input logic [7:0] s_mp);
      int elig [4];
      int win;
      rst = s_rst; stall = s_stall; en = s_en; miss = s_miss; mp = s_mp;
      if (s_rst) begin
         m_choice = 0; m_valid = 0; m_last = 3;
         for (int t = 0; t < 4; t++) m_pen[t] = 0;
      end else begin
         for (int t = 0; t < 4; t++)
            elig[t] = (s_en[t] && !s_miss[t] && m_pen[t] == 0 && !s_mp[2*t]) ? 1 : 0;
         if (!s_stall) begin
            win = -1;
            for (int k = 1; k <= 4; k++)
               if (win < 0 && elig[(m_last + k) % 4] == 1) win = (m_last + k) % 4;
            if (win >= 0) begin
               m_choice = win; m_valid = 1; m_last = win;
            end else begin
               m_valid = 0;
            end
         end
         for (int t = 0; t < 4; t++) begin
            if (s_mp[2*t]) m_pen[t] = FP;
            else if (m_pen[t] > 0) m_pen[t] = m_pen[t] - 1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step(1'b1, 1'b1, 4'b1111, 4'b0000, 8'h55);
      step(1'b1, 1'b0, 4'b1111, 4'b0000, 8'h00);
      n_checks++;
      if (choice !== 2'd0 || valid !== 1'b0 || busy !== 4'b0000) begin
         n_errors++;
         $display("FAIL reset_state: got choice=%0d valid=%0b busy=%b, want 0 0 0000", choice, valid, busy);
      end
   endtask

   task automatic test_rotation();
      int exp_seq [5] = '{0, 1, 2, 3, 0};
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, 4'b1111, 4'b0000, 8'h00);
         n_checks++;
         if (choice !== 2'(exp_seq[i]) || valid !== 1'b1) begin
            n_errors++;
            $display("FAIL rotation[%0d]: got choice=%0d valid=%0b, want %0d 1", i, choice, valid, exp_seq[i]);
         end
      end
   endtask

   task automatic test_alternate();
      int exp_seq [4] = '{1, 3, 1, 3};
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 4'b1010, 4'b0000, 8'h00);
         n_checks++;
         if (choice !== 2'(exp_seq[i]) || valid !== 1'b1) begin
            n_errors++;
            $display("FAIL alternate[%0d]: got choice=%0d valid=%0b, want %0d 1", i, choice, valid, exp_seq[i]);
         end
      end
   endtask

   task automatic test_mispredict();
      int       exp_ch [6] = '{0, 1, 3, 0, 1, 2};
      logic [5:0] exp_b2 = 6'b000111;
      step(1'b1, 1'b0, 4'b1111, 4'b0000, 8'h00);
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b0, 4'b1111, 4'b0000, (i == 0) ? 8'b0001_0000 : 8'h00);
         n_checks++;
         if (choice !== 2'(exp_ch[i]) || valid !== 1'b1 || busy[2] !== exp_b2[i]) begin
            n_errors++;
            $display("FAIL mispredict[%0d]: got choice=%0d valid=%0b busy2=%0b, want %0d 1 %0b",
                     i, choice, valid, busy[2], exp_ch[i], exp_b2[i]);
         end
      end
   endtask

   task automatic test_all_miss();
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 1'b0, 4'b1111, 4'b1111, 8'h00);
         n_checks++;
         if (valid !== 1'b0 || choice !== 2'd2) begin
            n_errors++;
            $display("FAIL all_miss[%0d]: got choice=%0d valid=%0b, want 2 0", i, choice, valid);
         end
      end
      step(1'b0, 1'b0, 4'b1111, 4'b1101, 8'h00);
      n_checks++;
      if (choice !== 2'd1 || valid !== 1'b1) begin
         n_errors++;
         $display("FAIL miss_release: got choice=%0d valid=%0b, want 1 1", choice, valid);
      end
   endtask

   task automatic test_stall();
      logic [2:0] exp_b3 = 3'b011;
      step(1'b1, 1'b0, 4'b1111, 4'b0000, 8'h00);
      step(1'b0, 1'b0, 4'b1111, 4'b0000, 8'h00);
      step(1'b0, 1'b0, 4'b1111, 4'b0000, 8'h00);
      step(1'b0, 1'b0, 4'b1111, 4'b0000, 8'b0100_0000);
      n_checks++;
      if (choice !== 2'd2 || busy[3] !== 1'b1) begin
         n_errors++;
         $display("FAIL stall_pre: got choice=%0d busy3=%0b, want 2 1", choice, busy[3]);
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 4'b1111, 4'b0000, 8'h00);
         n_checks++;
         if (choice !== 2'd2 || valid !== 1'b1 || busy[3] !== exp_b3[i]) begin
            n_errors++;
            $display("FAIL stall_frozen[%0d]: got choice=%0d valid=%0b busy3=%0b, want 2 1 %0b",
                     i, choice, valid, busy[3], exp_b3[i]);
         end
      end
      step(1'b0, 1'b0, 4'b1111, 4'b0000, 8'h00);
      n_checks++;
      if (choice !== 2'd3 || valid !== 1'b1) begin
         n_errors++;
         $display("FAIL stall_resume: got choice=%0d valid=%0b, want 3 1", choice, valid);
      end
   endtask

   task automatic test_reset_mid();
      step(1'b1, 1'b0, 4'b1111, 4'b0000, 8'h00);
      step(1'b0, 1'b0, 4'b1111, 4'b0000, 8'b0000_0001);
      step(1'b0, 1'b1, 4'b1111, 4'b0000, 8'h00);
      n_checks++;
      if (choice !== 2'd1 || busy !== 4'b0001) begin
         n_errors++;
         $display("FAIL reset_mid_setup: got choice=%0d busy=%b, want 1 0001", choice, busy);
      end
      step(1'b1, 1'b1, 4'b1111, 4'b0000, 8'b0000_0001);
      n_checks++;
      if (choice !== 2'd0 || valid !== 1'b0 || busy !== 4'b0000) begin
         n_errors++;
         $display("FAIL reset_mid: got choice=%0d valid=%0b busy=%b, want 0 0 0000", choice, valid, busy);
      end
      step(1'b0, 1'b0, 4'b1111, 4'b0000, 8'h00);
      n_checks++;
      if (choice !== 2'd0 || valid !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_mid_first: got choice=%0d valid=%0b, want 0 1", choice, valid);
      end
   endtask

   task automatic test_random();
      logic [7:0] r_mp;
      for (int i = 0; i < 400; i++) begin
         r_mp = 8'($urandom);
         if ($urandom_range(3, 0) != 0) r_mp = r_mp & 8'hAA;
         step(($urandom_range(39, 0) == 0), ($urandom_range(4, 0) == 0),
              4'($urandom), 4'($urandom) & 4'($urandom), r_mp);
         n_checks++;
         if (valid !== 1'(m_valid) || busy !== model_busy() ||
             (m_valid == 1 && choice !== 2'(m_choice))) begin
            n_errors++;
            $display("FAIL random[%0d]: got choice=%0d valid=%0b busy=%b, want %0d %0d %b",
                     i, choice, valid, busy, m_choice, m_valid, model_busy());
         end
      end
   endtask

   initial begin
      for (int t = 0; t < 4; t++) m_pen[t] = 0;
      test_reset();
      test_rotation();
      test_alternate();
      test_mispredict();
      test_all_miss();
      test_stall();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
